// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals around mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              gpu_req;
    logic              gpu_we;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wdata;
    logic [DATA_W-1:0] gpu_rdata;
    logic              gpu_ack;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;

    logic              mem_read;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_read_ack;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [DATA_W-1:0] mem_write_data;

    logic              busy;
    logic [1:0]        grant;
    logic              timeout_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  gpu_req, gpu_we, gpu_addr, gpu_wdata,
        output gpu_rdata, gpu_ack,
        input  ld_req, ld_addr, ld_wdata,
        output ld_ack,
        output mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
        input  mem_read_data, mem_read_ack,
        output busy, grant, timeout_err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output gpu_req, gpu_we, gpu_addr, gpu_wdata,
        input  gpu_rdata, gpu_ack,
        output ld_req, ld_addr, ld_wdata,
        input  ld_ack,
        input  mem_read, mem_read_addr, mem_write, mem_write_addr, mem_write_data,
        output mem_read_data, mem_read_ack,
        input  busy, grant, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way memory arbiter: loader has fixed priority, CPU and GPU share
// round-robin. One transaction at a time, all outputs registered.
//
// state | meaning
// IDLE  | sample requests, pick a winner
// ISSUE | single-cycle mem_read or mem_write strobe
// WAIT  | read outstanding, down-counting towards timeout
// DONE  | one-cycle ack to the granted requester
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_LD   = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_GPU  = 2'd3;
    // WAIT lasts WAIT_LOAD+1 cycles before giving up
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              rr_gpu;
    logic              lat_we;
    logic [7:0]        wait_cnt;
    logic [1:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        ack_sel;
    logic [DATA_W-1:0] rd_val;

    // Winner selection and request mux for the IDLE sample
    always_comb begin
        win = G_NONE;
        if (bus.ld_req)
            win = G_LD;
        else if (bus.cpu_req && bus.gpu_req)
            win = rr_gpu ? G_GPU : G_CPU;
        else if (bus.cpu_req)
            win = G_CPU;
        else if (bus.gpu_req)
            win = G_GPU;

        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        case (win)
            G_LD: begin
                sel_we    = 1'b1;
                sel_addr  = bus.ld_addr;
                sel_wdata = bus.ld_wdata;
            end
            G_GPU: begin
                sel_we    = bus.gpu_we;
                sel_addr  = bus.gpu_addr;
                sel_wdata = bus.gpu_wdata;
            end
            default: ;
        endcase

        case (bus.grant)
            G_LD:    ack_sel = 3'b001;
            G_CPU:   ack_sel = 3'b010;
            G_GPU:   ack_sel = 3'b100;
            default: ack_sel = 3'b000;
        endcase

        rd_val = bus.mem_read_ack ? bus.mem_read_data : '0;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win != G_NONE) state_nxt = ISSUE;
            ISSUE: state_nxt = lat_we ? DONE : WAIT;
            WAIT:  if (bus.mem_read_ack || wait_cnt == 8'd0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Registered outputs, latched request and timeout counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_gpu             <= 1'b0;
            lat_we             <= 1'b0;
            wait_cnt           <= 8'd0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_read_addr  <= '0;
            bus.mem_write_addr <= '0;
            bus.mem_write_data <= '0;
            bus.cpu_rdata      <= '0;
            bus.gpu_rdata      <= '0;
            bus.cpu_ack        <= 1'b0;
            bus.gpu_ack        <= 1'b0;
            bus.ld_ack         <= 1'b0;
            bus.busy           <= 1'b0;
            bus.grant          <= G_NONE;
            bus.timeout_err    <= 1'b0;
        end else begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            {bus.gpu_ack, bus.cpu_ack, bus.ld_ack} <= 3'b000;
            case (state)
                IDLE: begin
                    if (win != G_NONE) begin
                        bus.grant <= win;
                        bus.busy  <= 1'b1;
                        lat_we    <= sel_we;
                        if (sel_we) begin
                            bus.mem_write      <= 1'b1;
                            bus.mem_write_addr <= sel_addr;
                            bus.mem_write_data <= sel_wdata;
                        end else begin
                            bus.mem_read      <= 1'b1;
                            bus.mem_read_addr <= sel_addr;
                        end
                        if (win == G_CPU)
                            rr_gpu <= 1'b1;
                        else if (win == G_GPU)
                            rr_gpu <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (lat_we)
                        {bus.gpu_ack, bus.cpu_ack, bus.ld_ack} <= ack_sel;
                    else
                        wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    if (bus.mem_read_ack || wait_cnt == 8'd0) begin
                        {bus.gpu_ack, bus.cpu_ack, bus.ld_ack} <= ack_sel;
                        if (bus.grant == G_CPU) bus.cpu_rdata <= rd_val;
                        if (bus.grant == G_GPU) bus.gpu_rdata <= rd_val;
                        if (!bus.mem_read_ack) bus.timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                DONE: begin
                    bus.grant <= G_NONE;
                    bus.busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences,
// with a scoreboard of expected strobes and acks and a behavioural memory.
module tb_mem_arbiter;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  who;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          dly;
        bit          drop;
    } vec_t;

    typedef struct {
        logic [1:0]  who;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  data;
        bit          to;
    } exp_t;

    exp_t        mem_q[$];
    exp_t        ack_q[$];
    logic [7:0]  mem_model [4096];
    logic [11:0] last_rd_addr;
    int          mem_pend, resp_delay, ack_cnt;
    bit          got_ack;
    logic [7:0]  exp_cpu_rd, exp_gpu_rd;
    logic        exp_to;
    int          tests = 0, fails = 0;
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] who, input logic we, input logic [11:0] addr,
                           input logic [7:0] wdata, input logic val);
        case (who)
            2'd1: begin bus.ld_req = val; bus.ld_addr = addr; bus.ld_wdata = wdata; end
            2'd2: begin bus.cpu_req = val; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; end
            2'd3: begin bus.gpu_req = val; bus.gpu_we = we; bus.gpu_addr = addr; bus.gpu_wdata = wdata; end
            default: ;
        endcase
    endtask

    task automatic monitor();
        exp_t e;
        logic [2:0] ackv;
        if (bus.mem_read || bus.mem_write) begin
            if (mem_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, bus.mem_read, bus.mem_write}, 0);
            end else begin
                e = mem_q.pop_front();
                chk("strobe_kind", {30'd0, bus.mem_read, bus.mem_write}, e.we ? 2'b01 : 2'b10);
                chk("strobe_grant", bus.grant, e.who);
                chk("strobe_busy", bus.busy, 1);
                if (e.we) begin
                    chk("wr_addr", bus.mem_write_addr, e.addr);
                    chk("wr_data", bus.mem_write_data, e.data);
                    mem_model[bus.mem_write_addr] = bus.mem_write_data;
                end else begin
                    chk("rd_addr", bus.mem_read_addr, e.addr);
                    last_rd_addr = bus.mem_read_addr;
                    mem_pend = resp_delay;
                end
            end
        end
        ackv = {bus.gpu_ack, bus.cpu_ack, bus.ld_ack};
        if (ackv != 3'b000) begin
            got_ack = 1'b1;
            ack_cnt++;
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", ackv, 0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_who", ackv, 3'b001 << (e.who - 2'd1));
                chk("ack_grant", bus.grant, e.who);
                if (!e.we && e.who == 2'd2) exp_cpu_rd = e.data;
                if (!e.we && e.who == 2'd3) exp_gpu_rd = e.data;
                if (e.to) exp_to = 1'b1;
                chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
                chk("gpu_rdata", bus.gpu_rdata, exp_gpu_rd);
                chk("timeout_err", bus.timeout_err, exp_to);
            end
        end
    endtask

    // One clock: memory model drives just after the edge, checks at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
        bus.mem_read_ack  = 1'b0;
        bus.mem_read_data = 8'($urandom);
        if (mem_pend > 0) begin
            mem_pend--;
            if (mem_pend == 0) begin
                bus.mem_read_ack  = 1'b1;
                bus.mem_read_data = mem_model[last_rd_addr];
            end
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.cpu_req = 1'b0; bus.gpu_req = 1'b0; bus.ld_req = 1'b0;
        mem_pend = 0;
        tick();
        tick();
        chk("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 0);
        chk("rst_acks", {29'd0, bus.gpu_ack, bus.cpu_ack, bus.ld_ack}, 0);
        chk("rst_busy_grant", {29'd0, bus.busy, bus.grant}, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_rdata", {16'd0, bus.cpu_rdata, bus.gpu_rdata}, 0);
        chk("rst_addr_data", {bus.mem_read_addr, bus.mem_write_addr, bus.mem_write_data}, 0);
        reset_n = 1'b1;
        mem_q.delete();
        ack_q.delete();
        exp_cpu_rd = 8'h00; exp_gpu_rd = 8'h00; exp_to = 1'b0;
    endtask

    function automatic exp_t mk(input logic [1:0] who, input logic we, input logic [11:0] addr,
                                input logic [7:0] data, input bit to);
        exp_t e;
        e.who = who; e.we = we; e.addr = addr; e.data = data; e.to = to;
        return e;
    endfunction

    initial begin
        int n, exp_lat;
        bit ld_raised;
        vec_t v;

        for (int i = 0; i < 4096; i++) mem_model[i] = 8'(i) ^ 8'h3C;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.gpu_req = 0; bus.gpu_we = 0; bus.gpu_addr = 0; bus.gpu_wdata = 0;
        bus.ld_req = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
        bus.mem_read_ack = 0; bus.mem_read_data = 0;
        mem_pend = 0; resp_delay = 0; ack_cnt = 0; got_ack = 0; last_rd_addr = 0;

        //          who   we    addr     wdata  rdata  dly drop
        vecs[0]  = '{2'd2, 1'b1, 12'h200, 8'hA2, 8'h00, 0,  0};
        vecs[1]  = '{2'd1, 1'b1, 12'h050, 8'hF0, 8'h00, 0,  0};
        vecs[2]  = '{2'd3, 1'b0, 12'h050, 8'h00, 8'hF0, 1,  0};
        vecs[3]  = '{2'd2, 1'b0, 12'h200, 8'h00, 8'hA2, 2,  0};
        vecs[4]  = '{2'd3, 1'b1, 12'hFFF, 8'h5C, 8'h00, 0,  0};
        vecs[5]  = '{2'd3, 1'b0, 12'hFFF, 8'h00, 8'h5C, 15, 0};
        vecs[6]  = '{2'd2, 1'b0, 12'h123, 8'h00, 8'h1F, 1,  1};
        vecs[7]  = '{2'd2, 1'b0, 12'h200, 8'h00, 8'h00, 0,  0};
        vecs[8]  = '{2'd3, 1'b0, 12'h7FF, 8'h00, 8'h00, 16, 0};
        vecs[9]  = '{2'd1, 1'b1, 12'h7FF, 8'h99, 8'h00, 0,  1};
        vecs[10] = '{2'd2, 1'b1, 12'h001, 8'h11, 8'h00, 0,  1};
        vecs[11] = '{2'd2, 1'b0, 12'h7FF, 8'h00, 8'h99, 3,  0};

        do_reset();

        foreach (vecs[k]) begin
            v = vecs[k];
            resp_delay = v.dly;
            mem_q.push_back(mk(v.who, v.we, v.addr, v.wdata, 0));
            ack_q.push_back(mk(v.who, v.we, v.addr, v.we ? 8'h00 : v.rdata,
                               !v.we && (v.dly == 0 || v.dly > TO)));
            exp_lat = v.we ? 2 : ((v.dly >= 1 && v.dly <= TO) ? 2 + v.dly : 2 + TO);
            set_req(v.who, v.we, v.addr, v.wdata, 1'b1);
            got_ack = 0;
            n = 0;
            while (!got_ack && n < 40) begin
                tick();
                n++;
                if (n == 1 && v.drop) set_req(v.who, v.we, v.addr, v.wdata, 1'b0);
            end
            chk("ack_seen", {31'd0, got_ack}, 1);
            chk("latency", n, exp_lat);
            set_req(v.who, v.we, v.addr, v.wdata, 1'b0);
            if (!got_ack) begin mem_q.delete(); ack_q.delete(); end
            tick();
            tick();
            chk("idle_busy", bus.busy, 0);
        end
        chk("sticky_timeout_err", bus.timeout_err, 1);

        // Round robin with a loader interjection
        do_reset();
        mem_q.push_back(mk(2'd2, 1, 12'h010, 8'h01, 0)); ack_q.push_back(mk(2'd2, 1, 12'h010, 8'h00, 0));
        mem_q.push_back(mk(2'd3, 1, 12'h020, 8'h02, 0)); ack_q.push_back(mk(2'd3, 1, 12'h020, 8'h00, 0));
        mem_q.push_back(mk(2'd1, 1, 12'h030, 8'h03, 0)); ack_q.push_back(mk(2'd1, 1, 12'h030, 8'h00, 0));
        mem_q.push_back(mk(2'd2, 1, 12'h010, 8'h01, 0)); ack_q.push_back(mk(2'd2, 1, 12'h010, 8'h00, 0));
        mem_q.push_back(mk(2'd3, 1, 12'h020, 8'h02, 0)); ack_q.push_back(mk(2'd3, 1, 12'h020, 8'h00, 0));
        set_req(2'd2, 1'b1, 12'h010, 8'h01, 1'b1);
        set_req(2'd3, 1'b1, 12'h020, 8'h02, 1'b1);
        ack_cnt = 0; n = 0; ld_raised = 0;
        while (ack_cnt < 5 && n < 80) begin
            tick();
            n++;
            if (ack_cnt == 2 && !ld_raised) begin
                set_req(2'd1, 1'b1, 12'h030, 8'h03, 1'b1);
                ld_raised = 1;
            end
            if (ack_cnt == 3) bus.ld_req = 1'b0;
        end
        bus.cpu_req = 1'b0; bus.gpu_req = 1'b0; bus.ld_req = 1'b0;
        chk("rr_acks", ack_cnt, 5);
        tick();
        tick();
        chk("rr_queue_empty", mem_q.size() + ack_q.size(), 0);

        // Reset while a read waits; a late mem_read_ack must be ignored
        resp_delay = 0;
        mem_q.push_back(mk(2'd2, 0, 12'h155, 8'h00, 0));
        set_req(2'd2, 1'b0, 12'h155, 8'h00, 1'b1);
        tick();
        tick();
        bus.cpu_req = 1'b0;
        chk("wait_busy", bus.busy, 1);
        reset_n = 1'b0;
        ack_cnt = 0;
        tick();
        chk("abort_busy_grant", {29'd0, bus.busy, bus.grant}, 0);
        chk("abort_strobes", {30'd0, bus.mem_read, bus.mem_write}, 0);
        reset_n = 1'b1;
        mem_pend = 1;
        tick();
        chk("late_ack_driven", {31'd0, bus.mem_read_ack}, 1);
        tick();
        tick();
        chk("late_ack_ignored", ack_cnt, 0);
        chk("late_ack_idle", {29'd0, bus.busy, bus.grant}, 0);
        chk("late_ack_rdata", bus.cpu_rdata, 0);
        chk("final_queue_empty", mem_q.size() + ack_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, max cycles waiting for mem_read_ack (range 1-255).
REQ-004 The block SHALL have ports: clk in 1, sole clock (rising edge); reset_n in 1, synchronous active-low reset.
REQ-005 The block SHALL have CPU ports: cpu_req in 1, request held until ack; cpu_we in 1, 1=write/0=read; cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_rdata out DATA_W, read data; cpu_ack out 1, one-cycle completion pulse.
REQ-006 The block SHALL have GPU ports gpu_req, gpu_we, gpu_addr, gpu_wdata, gpu_rdata, gpu_ack, identical in width and meaning to the CPU ports.
REQ-007 The block SHALL have loader ports: ld_req in 1; ld_addr in ADDR_W; ld_wdata in DATA_W; ld_ack out 1 (write-only requester).
REQ-008 The block SHALL have memory ports: mem_read out 1; mem_read_addr out ADDR_W; mem_read_data in DATA_W; mem_read_ack in 1; mem_write out 1; mem_write_addr out ADDR_W; mem_write_data out DATA_W.
REQ-009 The block SHALL have status ports: busy out 1, high in any state but IDLE; grant out 2, 0=none/1=loader/2=cpu/3=gpu; timeout_err out 1, sticky read-timeout flag.

Function
REQ-010 All outputs SHALL be registered; FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-011 In IDLE, the block SHALL sample requests; priority: ld_req first, then cpu_req/gpu_req round-robin.
REQ-012 Round-robin: pointer starts at CPU, flips to the other requester after each CPU or GPU grant; loader grants leave it unchanged.
REQ-013 On grant in cycle N, addr/we/wdata SHALL be latched, grant set to the winner, state to ISSUE for cycle N+1.
REQ-014 ISSUE: exactly one of mem_read/mem_write high for exactly one cycle (N+1), with latched addr/data on the matching bus.
REQ-015 Write: ISSUE -> DONE; requester ack high in N+2 only.
REQ-016 Read: ISSUE -> WAIT; on mem_read_ack high, capture mem_read_data and go to DONE; nominal rdata+ack in N+3.
REQ-017 WAIT SHALL count cycles; if mem_read_ack is still low after TIMEOUT cycles in WAIT, go to DONE with rdata=0 and timeout_err set.
REQ-018 mem_read_ack outside WAIT SHALL be ignored.
REQ-019 DONE: the granted requester's ack high for one cycle, no requests sampled; next state IDLE, grant returns to 0.
REQ-020 rdata of each requester SHALL hold its last read value until that requester's next read completes; writes SHALL NOT change rdata.
REQ-021 Requesters SHALL deassert or change req by the cycle after ack; req high in IDLE SHALL always start a new transaction.
REQ-022 Dropping req after grant SHALL NOT abort: the transaction completes and ack still pulses.
REQ-023 Simultaneous ld/cpu/gpu requests SHALL be served one per transaction, with no requester starved while its req stays high.
REQ-024 Addresses SHALL pass unmodified (no wrap or offset); widths follow ADDR_W/DATA_W.

Reset
REQ-025 With reset_n low at a rising edge: state=IDLE; mem_read, mem_write, all acks, busy, timeout_err = 0; grant=0; rdata, addr and data outputs = 0; round-robin pointer = CPU.
REQ-026 Reset mid-transaction SHALL abandon it with no ack, and no mem strobe in the cycle after reset.

Verification
REQ-027 CPU write addr 0x200 data 0xA2 -> mem_write pulses in N+1 with addr 0x200/data 0xA2; cpu_ack in N+2 only; grant=2 during N+1..N+2.
REQ-028 GPU read 0x050, memory returns 0xF0 with ack one cycle after mem_read -> gpu_rdata=0xF0 and gpu_ack high in N+3; cpu_rdata unchanged.
REQ-029 cpu_req and gpu_req held high for 4 transactions -> grants alternate CPU, GPU, CPU, GPU; ld_req raised meanwhile -> loader wins the next IDLE, then alternation resumes.
REQ-030 Read with mem_read_ack held low, TIMEOUT=15 -> ack with rdata=0 after 15 WAIT cycles; timeout_err=1 until reset.
REQ-031 reset_n low during WAIT -> no ack, busy=0 and grant=0 next cycle; a later mem_read_ack is ignored.
REQ-032 Requester drops req during ISSUE -> transaction completes and its ack still pulses once.
